// File: rtl/commit_ctrl_nw_pkg.sv
// Shared types and constants for the wide commit controller.
package commit_pkg;

  // Controller state: normal commit, multi-cycle flush hold, idle until interrupt.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_IDLE_WAIT = 2'd2
  } commit_state_e;

  // Interrupts are reported with ecode/esubcode zero.
  localparam logic [5:0] ECODE_INT    = 6'h00;
  localparam logic [8:0] ESUBCODE_INT = 9'h000;

  // Per-slot view of one commit-group entry (GPR address is kept separate
  // because its width is a module parameter).
  typedef struct packed {
    logic [31:0] pc;
    logic        excp;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badv;
    logic        ertn;
    logic        idle;
    logic        reg_we;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
  } commit_slot_t;

endpackage

// File: rtl/commit_ctrl_nw_pause_therm.sv
// Priority-to-thermometer encoder: every stage at or below the highest
// requesting stage is paused so younger work never overtakes a stall.
module pause_therm #(
  parameter int PIPE_WIDTH = 8
) (
  input  logic [PIPE_WIDTH-1:0] req_i,
  output logic [PIPE_WIDTH-1:0] therm_o
);

  // Running OR from the oldest stage down to the PC stage.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    therm_o = '0;
    for (int i = PIPE_WIDTH - 1; i >= 0; i--) begin
      acc        = acc | req_i[i];
      therm_o[i] = acc;
    end
  end

endmodule

// File: rtl/commit_ctrl_nw.sv
// Wide commit controller: retires an age-ordered commit group, arbitrates
// exception/interrupt, ertn, idle and branch redirects, and drives pause/flush.
module commit_ctrl_nw
  import commit_pkg::*;
#(
  parameter int ISSUE_WIDTH    = 2,
  parameter int PIPE_WIDTH     = 8,
  parameter int BR_FLUSH_LO    = 3,
  parameter int FLUSH_CYCLES   = 1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ISSUE_WIDTH-1:0]               slot_valid,
  input  logic [ISSUE_WIDTH*32-1:0]            slot_pc,
  input  logic [ISSUE_WIDTH-1:0]               slot_excp,
  input  logic [ISSUE_WIDTH*6-1:0]             slot_ecode,
  input  logic [ISSUE_WIDTH*9-1:0]             slot_esubcode,
  input  logic [ISSUE_WIDTH*32-1:0]            slot_badv,
  input  logic [ISSUE_WIDTH-1:0]               slot_ertn,
  input  logic [ISSUE_WIDTH-1:0]               slot_idle,
  input  logic [ISSUE_WIDTH-1:0]               slot_reg_we,
  input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] slot_reg_waddr,
  input  logic [ISSUE_WIDTH*32-1:0]            slot_reg_wdata,
  input  logic [ISSUE_WIDTH-1:0]               slot_csr_we,
  input  logic [ISSUE_WIDTH*14-1:0]            slot_csr_waddr,
  input  logic [ISSUE_WIDTH*32-1:0]            slot_csr_wdata,
  input  logic                                 branch_flush,
  input  logic [31:0]                          branch_target,
  input  logic [PIPE_WIDTH-1:0]                pause_req,
  input  logic                                 crmd_ie,
  input  logic [12:0]                          ecfg_lie,
  input  logic [12:0]                          estat_is,
  input  logic [31:0]                          csr_era,
  input  logic [31:0]                          csr_eentry,
  output logic [PIPE_WIDTH-1:0]                pause,
  output logic [PIPE_WIDTH-1:0]                flush,
  output logic                                 redirect,
  output logic [31:0]                          new_pc,
  output logic [ISSUE_WIDTH-1:0]               reg_we,
  output logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [ISSUE_WIDTH*32-1:0]            reg_wdata,
  output logic                                 csr_we,
  output logic [13:0]                          csr_waddr,
  output logic [31:0]                          csr_wdata,
  output logic                                 excp_valid,
  output logic [31:0]                          excp_pc,
  output logic [31:0]                          excp_badv,
  output logic [5:0]                           excp_ecode,
  output logic [8:0]                           excp_esubcode,
  output logic                                 ertn_valid,
  output logic                                 is_interrupt,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]     commit_cnt,
  output logic [63:0]                          retired_cnt,
  output logic [1:0]                           state_o
);

  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);
  localparam int FCW   = $clog2(FLUSH_CYCLES + 1);
  localparam int RAW   = REG_ADDR_WIDTH;
  // Full flush/idle pause covers everything except the wb stage.
  localparam logic [PIPE_WIDTH-1:0] FULL_MASK = {1'b0, {(PIPE_WIDTH-1){1'b1}}};
  localparam logic [PIPE_WIDTH-1:0] BR_MASK   = FULL_MASK & ({PIPE_WIDTH{1'b1}} << BR_FLUSH_LO);

  commit_state_e         state_q, state_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [31:0]           idle_pc_q, idle_pc_d;
  logic [63:0]           retired_q;
  logic [PIPE_WIDTH-1:0] therm;
  logic                  int_pend;
  commit_slot_t          slot [ISSUE_WIDTH];

  logic [ISSUE_WIDTH-1:0] commit_v, reg_we_raw;
  logic                   can_commit, stop, enter_hold;
  logic                   ev_excp, ev_ertn, ev_idle;
  logic [31:0]            ev_pc, ev_badv, idle_next_pc;
  logic [5:0]             ev_ecode;
  logic [8:0]             ev_esub;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_unpack
    assign slot[g] = '{pc: slot_pc[g*32 +: 32], excp: slot_excp[g],
                       ecode: slot_ecode[g*6 +: 6], esubcode: slot_esubcode[g*9 +: 9],
                       badv: slot_badv[g*32 +: 32], ertn: slot_ertn[g], idle: slot_idle[g],
                       reg_we: slot_reg_we[g], csr_we: slot_csr_we[g],
                       csr_waddr: slot_csr_waddr[g*14 +: 14], csr_wdata: slot_csr_wdata[g*32 +: 32]};
  end

  assign int_pend    = crmd_ie & (|(ecfg_lie & estat_is));
  assign state_o     = state_q;
  assign retired_cnt = retired_q;

  pause_therm #(.PIPE_WIDTH(PIPE_WIDTH)) u_pause_therm (
    .req_i   (pause_req),
    .therm_o (therm)
  );

  // Commit selection, redirect arbitration and next-state computation.
  always_comb begin
    pause = '0; flush = '0; redirect = 1'b0; new_pc = '0;
    reg_we = '0; reg_waddr = '0; reg_wdata = '0;
    csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
    excp_valid = 1'b0; excp_pc = '0; excp_badv = '0; excp_ecode = '0; excp_esubcode = '0;
    ertn_valid = 1'b0; is_interrupt = 1'b0; commit_cnt = '0;
    commit_v = '0; reg_we_raw = '0; can_commit = 1'b0; stop = 1'b0; enter_hold = 1'b0;
    ev_excp = 1'b0; ev_ertn = 1'b0; ev_idle = 1'b0;
    ev_pc = '0; ev_badv = '0; ev_ecode = '0; ev_esub = '0; idle_next_pc = '0;
    state_d = state_q; flush_cnt_d = flush_cnt_q; idle_pc_d = idle_pc_q;

    if (!rst) begin
      is_interrupt = int_pend;
      pause        = (state_q == ST_IDLE_WAIT) ? FULL_MASK : therm;
      can_commit   = (state_q == ST_RUN) && !pause[0];

      // Walk oldest to youngest; the first event stops the group.
      if (can_commit) begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
          if (!stop && slot_valid[j]) begin
            if (int_pend || slot[j].excp) begin
              stop     = 1'b1;
              ev_excp  = 1'b1;
              ev_pc    = slot[j].pc;
              ev_badv  = slot[j].badv;
              ev_ecode = int_pend ? ECODE_INT : slot[j].ecode;
              ev_esub  = int_pend ? ESUBCODE_INT : slot[j].esubcode;
            end else begin
              commit_v[j] = 1'b1;
              if (slot[j].ertn) begin
                stop    = 1'b1;
                ev_ertn = 1'b1;
              end else if (slot[j].idle) begin
                stop         = 1'b1;
                ev_idle      = 1'b1;
                idle_next_pc = slot[j].pc + 32'd4;
              end
            end
          end
        end
      end

      reg_waddr = slot_reg_waddr;
      reg_wdata = slot_reg_wdata;
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (commit_v[j]) commit_cnt = commit_cnt + CNT_W'(1);
        reg_we_raw[j] = commit_v[j] && slot[j].reg_we && (slot_reg_waddr[j*RAW +: RAW] != '0);
        if (commit_v[j] && slot[j].csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = slot[j].csr_waddr;
          csr_wdata = slot[j].csr_wdata;
        end
      end
      // A younger committing write to the same register shadows older ones.
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        reg_we[j] = reg_we_raw[j];
        for (int m = j + 1; m < ISSUE_WIDTH; m++) begin
          if (reg_we_raw[m] && (slot_reg_waddr[m*RAW +: RAW] == slot_reg_waddr[j*RAW +: RAW]))
            reg_we[j] = 1'b0;
        end
      end

      case (state_q)
        ST_IDLE_WAIT: begin
          if (int_pend) begin
            excp_valid = 1'b1;
            excp_pc    = idle_pc_q;
            redirect   = 1'b1;
            new_pc     = csr_eentry;
            flush      = FULL_MASK;
            state_d    = ST_RUN;
            enter_hold = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush = FULL_MASK;
          if (flush_cnt_q <= FCW'(1)) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FCW'(1);
          end
        end
        default: begin
          if (ev_excp) begin
            excp_valid    = 1'b1;
            excp_pc       = ev_pc;
            excp_badv     = ev_badv;
            excp_ecode    = ev_ecode;
            excp_esubcode = ev_esub;
            redirect      = 1'b1;
            new_pc        = csr_eentry;
            flush         = FULL_MASK;
            enter_hold    = 1'b1;
          end else if (ev_ertn) begin
            ertn_valid = 1'b1;
            redirect   = 1'b1;
            new_pc     = csr_era;
            flush      = FULL_MASK;
            enter_hold = 1'b1;
          end else if (ev_idle) begin
            redirect  = 1'b1;
            new_pc    = idle_next_pc;
            flush     = FULL_MASK;
            state_d   = ST_IDLE_WAIT;
            idle_pc_d = idle_next_pc;
          end else if (branch_flush) begin
            redirect = 1'b1;
            new_pc   = branch_target;
            flush    = BR_MASK;
          end
        end
      endcase

      if (enter_hold && (FLUSH_CYCLES > 1)) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
      end
    end
  end

  // State, flush hold counter, idle resume PC and retired counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      idle_pc_q   <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      idle_pc_q   <= idle_pc_d;
      retired_q   <= retired_q + 64'(commit_cnt);
    end
  end

endmodule

// File: tb/tb_commit_ctrl_nw.sv
// Directed scoreboard bench for commit_ctrl_nw (default instance plus a
// FLUSH_CYCLES=3 instance sharing the same stimulus).
module tb_commit_ctrl_nw;

  logic        clk, rst;
  logic [1:0]  slot_valid, slot_excp, slot_ertn, slot_idle, slot_reg_we, slot_csr_we;
  logic [63:0] slot_pc, slot_badv, slot_reg_wdata, slot_csr_wdata;
  logic [11:0] slot_ecode;
  logic [17:0] slot_esubcode;
  logic [9:0]  slot_reg_waddr;
  logic [27:0] slot_csr_waddr;
  logic        branch_flush, crmd_ie;
  logic [31:0] branch_target, csr_era, csr_eentry;
  logic [7:0]  pause_req;
  logic [12:0] ecfg_lie, estat_is;

  logic [7:0]  a_pause, a_flush, b_pause, b_flush;
  logic        a_redirect, b_redirect, a_csr_we, b_csr_we, a_excp_valid, b_excp_valid;
  logic        a_ertn_valid, b_ertn_valid, a_is_int, b_is_int;
  logic [31:0] a_new_pc, b_new_pc, a_csr_wdata, b_csr_wdata;
  logic [31:0] a_excp_pc, b_excp_pc, a_excp_badv, b_excp_badv;
  logic [1:0]  a_reg_we, b_reg_we, a_commit_cnt, b_commit_cnt, a_state, b_state;
  logic [9:0]  a_reg_waddr, b_reg_waddr;
  logic [63:0] a_reg_wdata, b_reg_wdata, a_retired, b_retired;
  logic [13:0] a_csr_waddr, b_csr_waddr;
  logic [5:0]  a_ecode, b_ecode;
  logic [8:0]  a_esub, b_esub;

  commit_ctrl_nw dut (
    .clk(clk), .rst(rst), .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_excp(slot_excp),
    .slot_ecode(slot_ecode), .slot_esubcode(slot_esubcode), .slot_badv(slot_badv),
    .slot_ertn(slot_ertn), .slot_idle(slot_idle), .slot_reg_we(slot_reg_we),
    .slot_reg_waddr(slot_reg_waddr), .slot_reg_wdata(slot_reg_wdata), .slot_csr_we(slot_csr_we),
    .slot_csr_waddr(slot_csr_waddr), .slot_csr_wdata(slot_csr_wdata), .branch_flush(branch_flush),
    .branch_target(branch_target), .pause_req(pause_req), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie),
    .estat_is(estat_is), .csr_era(csr_era), .csr_eentry(csr_eentry),
    .pause(a_pause), .flush(a_flush), .redirect(a_redirect), .new_pc(a_new_pc),
    .reg_we(a_reg_we), .reg_waddr(a_reg_waddr), .reg_wdata(a_reg_wdata),
    .csr_we(a_csr_we), .csr_waddr(a_csr_waddr), .csr_wdata(a_csr_wdata),
    .excp_valid(a_excp_valid), .excp_pc(a_excp_pc), .excp_badv(a_excp_badv),
    .excp_ecode(a_ecode), .excp_esubcode(a_esub), .ertn_valid(a_ertn_valid),
    .is_interrupt(a_is_int), .commit_cnt(a_commit_cnt), .retired_cnt(a_retired), .state_o(a_state)
  );

  commit_ctrl_nw #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_excp(slot_excp),
    .slot_ecode(slot_ecode), .slot_esubcode(slot_esubcode), .slot_badv(slot_badv),
    .slot_ertn(slot_ertn), .slot_idle(slot_idle), .slot_reg_we(slot_reg_we),
    .slot_reg_waddr(slot_reg_waddr), .slot_reg_wdata(slot_reg_wdata), .slot_csr_we(slot_csr_we),
    .slot_csr_waddr(slot_csr_waddr), .slot_csr_wdata(slot_csr_wdata), .branch_flush(branch_flush),
    .branch_target(branch_target), .pause_req(pause_req), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie),
    .estat_is(estat_is), .csr_era(csr_era), .csr_eentry(csr_eentry),
    .pause(b_pause), .flush(b_flush), .redirect(b_redirect), .new_pc(b_new_pc),
    .reg_we(b_reg_we), .reg_waddr(b_reg_waddr), .reg_wdata(b_reg_wdata),
    .csr_we(b_csr_we), .csr_waddr(b_csr_waddr), .csr_wdata(b_csr_wdata),
    .excp_valid(b_excp_valid), .excp_pc(b_excp_pc), .excp_badv(b_excp_badv),
    .excp_ecode(b_ecode), .excp_esubcode(b_esub), .ertn_valid(b_ertn_valid),
    .is_interrupt(b_is_int), .commit_cnt(b_commit_cnt), .retired_cnt(b_retired), .state_o(b_state)
  );

  typedef struct {
    string       tag;
    logic [7:0]  pause, flush;
    logic        redirect;
    logic [31:0] new_pc;
    logic [1:0]  reg_we;
    logic        csr_we, excp_valid;
    logic [31:0] excp_pc, excp_badv;
    logic [5:0]  ecode;
    logic        ertn, intr;
    logic [1:0]  cnt, state;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_ret = 0;

  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000300;
  localparam logic [31:0] BTGT   = 32'h1c00aaa0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ex(input string tag);
    exp_t e;
    e.tag = tag; e.pause = 8'h00; e.flush = 8'h00; e.redirect = 1'b0; e.new_pc = 32'h0;
    e.reg_we = 2'b00; e.csr_we = 1'b0; e.excp_valid = 1'b0; e.excp_pc = 32'h0;
    e.excp_badv = 32'h0; e.ecode = 6'h0; e.ertn = 1'b0; e.intr = 1'b0; e.cnt = 2'd0; e.state = 2'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare the oldest scoreboard entry against the default instance.
  task automatic pop_check();
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".pause"},    64'(a_pause),      64'(e.pause));
    chk({e.tag, ".flush"},    64'(a_flush),      64'(e.flush));
    chk({e.tag, ".redirect"}, 64'(a_redirect),   64'(e.redirect));
    chk({e.tag, ".new_pc"},   64'(a_new_pc),     64'(e.new_pc));
    chk({e.tag, ".reg_we"},   64'(a_reg_we),     64'(e.reg_we));
    chk({e.tag, ".csr_we"},   64'(a_csr_we),     64'(e.csr_we));
    chk({e.tag, ".excp_v"},   64'(a_excp_valid), 64'(e.excp_valid));
    chk({e.tag, ".excp_pc"},  64'(a_excp_pc),    64'(e.excp_pc));
    chk({e.tag, ".badv"},     64'(a_excp_badv),  64'(e.excp_badv));
    chk({e.tag, ".ecode"},    64'(a_ecode),      64'(e.ecode));
    chk({e.tag, ".ertn"},     64'(a_ertn_valid), 64'(e.ertn));
    chk({e.tag, ".intr"},     64'(a_is_int),     64'(e.intr));
    chk({e.tag, ".cnt"},      64'(a_commit_cnt), 64'(e.cnt));
    chk({e.tag, ".state"},    64'(a_state),      64'(e.state));
    chk({e.tag, ".retired"},  a_retired,         exp_ret);
    exp_ret = exp_ret + 64'(e.cnt);
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    pop_check();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    slot_valid = '0; slot_pc = '0; slot_excp = '0; slot_ecode = '0; slot_esubcode = '0;
    slot_badv = '0; slot_ertn = '0; slot_idle = '0; slot_reg_we = '0; slot_reg_waddr = '0;
    slot_reg_wdata = '0; slot_csr_we = '0; slot_csr_waddr = '0; slot_csr_wdata = '0;
    branch_flush = 1'b0; branch_target = '0; pause_req = '0;
    crmd_ie = 1'b0; ecfg_lie = '0; estat_is = '0;
  endtask

  task automatic slot(input int j, input logic [31:0] pc);
    slot_valid[j] = 1'b1;
    slot_pc[j*32 +: 32] = pc;
  endtask

  task automatic regw(input int j, input logic [4:0] a, input logic [31:0] d);
    slot_reg_we[j] = 1'b1;
    slot_reg_waddr[j*5 +: 5] = a;
    slot_reg_wdata[j*32 +: 32] = d;
  endtask

  task automatic raise_int();
    crmd_ie = 1'b1; ecfg_lie = 13'h0800; estat_is = 13'h0800;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      nxt(); clr();
      step(ex("bubble"));
    end
  endtask

  initial begin
    exp_t e;
    clr();
    csr_era = ERA; csr_eentry = EENTRY;
    rst = 1'b1;
    // Busy inputs during reset must not leak to outputs.
    slot(0, 32'h1c000000); slot_excp[0] = 1'b1; pause_req = 8'h08; raise_int();
    #3;
    chk("rst.pause", 64'(a_pause), 64'h0);
    chk("rst.flush", 64'(a_flush), 64'h0);
    chk("rst.redirect", 64'(a_redirect), 64'h0);
    chk("rst.excp_v", 64'(a_excp_valid), 64'h0);
    chk("rst.intr", 64'(a_is_int), 64'h0);
    chk("rst.state", 64'(a_state), 64'h0);
    chk("rst.retired", a_retired, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; clr();

    // Same destination in both slots: only the younger write survives.
    nxt(); clr();
    slot(0, 32'h1c000000); regw(0, 5'd5, 32'h11);
    slot(1, 32'h1c000004); regw(1, 5'd5, 32'h22);
    e = ex("dup_r5"); e.reg_we = 2'b10; e.cnt = 2'd2; step(e);
    chk("dup_r5.wdata1", 64'(a_reg_wdata[63:32]), 64'h22);

    // r0 write dropped; CSR write from slot 1.
    nxt(); clr();
    slot(0, 32'h1c000008); regw(0, 5'd0, 32'h33);
    slot(1, 32'h1c00000c); regw(1, 5'd7, 32'h44);
    slot_csr_we[1] = 1'b1; slot_csr_waddr[27:14] = 14'h006; slot_csr_wdata[63:32] = 32'habc;
    e = ex("r0_csr"); e.reg_we = 2'b10; e.csr_we = 1'b1; e.cnt = 2'd2; step(e);
    chk("r0_csr.waddr", 64'(a_csr_waddr), 64'h006);
    chk("r0_csr.wdata", 64'(a_csr_wdata), 64'habc);

    // Exception in slot 1: slot 0 retires, slot 1 killed.
    nxt(); clr();
    slot(0, 32'h1c000010); regw(0, 5'd3, 32'h1);
    slot(1, 32'h1c000014); regw(1, 5'd4, 32'h2);
    slot_excp[1] = 1'b1; slot_ecode[11:6] = 6'h09; slot_badv[63:32] = 32'h1003;
    e = ex("excp1"); e.reg_we = 2'b01; e.cnt = 2'd1; e.excp_valid = 1'b1;
    e.excp_pc = 32'h1c000014; e.excp_badv = 32'h1003; e.ecode = 6'h09;
    e.flush = 8'h7F; e.redirect = 1'b1; e.new_pc = EENTRY; step(e);
    chk("fc3.c1.flush", 64'(b_flush), 64'h7F);
    // Branch during the hold: taken by the 1-cycle instance, ignored by the 3-cycle one.
    for (int c = 2; c <= 3; c++) begin
      nxt(); clr(); branch_flush = 1'b1; branch_target = BTGT;
      e = ex("br_hold"); e.redirect = 1'b1; e.new_pc = BTGT; e.flush = 8'h78; step(e);
      chk("fc3.hold.flush", 64'(b_flush), 64'h7F);
      chk("fc3.hold.redirect", 64'(b_redirect), 64'h0);
      chk("fc3.hold.state", 64'(b_state), 64'h1);
    end
    nxt(); clr(); branch_flush = 1'b1; branch_target = BTGT;
    e = ex("br_run"); e.redirect = 1'b1; e.new_pc = BTGT; e.flush = 8'h78; step(e);
    chk("fc3.after.state", 64'(b_state), 64'h0);
    chk("fc3.after.flush", 64'(b_flush), 64'h78);

    // Interrupt overrides ertn in slot 0.
    nxt(); clr(); raise_int();
    slot(0, 32'h1c000200); slot_ertn[0] = 1'b1;
    slot(1, 32'h1c000204); regw(1, 5'd6, 32'h5);
    e = ex("int_ertn"); e.excp_valid = 1'b1; e.excp_pc = 32'h1c000200; e.intr = 1'b1;
    e.flush = 8'h7F; e.redirect = 1'b1; e.new_pc = EENTRY; step(e);
    bubble(2);

    // Plain ertn: slot 0 retires, slot 1 killed.
    nxt(); clr();
    slot(0, 32'h1c000210); slot_ertn[0] = 1'b1;
    slot(1, 32'h1c000214); regw(1, 5'd6, 32'h6);
    e = ex("ertn"); e.ertn = 1'b1; e.redirect = 1'b1; e.new_pc = ERA; e.flush = 8'h7F;
    e.cnt = 2'd1; step(e);
    bubble(2);

    // Stall holds back a pending exception until the pause drops.
    for (int c = 0; c < 2; c++) begin
      nxt(); clr(); pause_req = 8'h08;
      slot(0, 32'h1c000220); slot_excp[0] = 1'b1; slot_ecode[5:0] = 6'h0a; slot_badv[31:0] = 32'h55;
      e = ex("paused"); e.pause = 8'h0F; step(e);
    end
    nxt(); pause_req = 8'h00;
    e = ex("unpaused"); e.excp_valid = 1'b1; e.excp_pc = 32'h1c000220; e.excp_badv = 32'h55;
    e.ecode = 6'h0a; e.flush = 8'h7F; e.redirect = 1'b1; e.new_pc = EENTRY; step(e);
    bubble(2);

    // idle in slot 0, then wait for an interrupt.
    nxt(); clr();
    slot(0, 32'h1c000100); slot_idle[0] = 1'b1;
    slot(1, 32'h1c000104); regw(1, 5'd9, 32'h9);
    e = ex("idle"); e.cnt = 2'd1; e.redirect = 1'b1; e.new_pc = 32'h1c000104; e.flush = 8'h7F;
    step(e);
    for (int c = 0; c < 10; c++) begin
      nxt(); clr(); slot(0, 32'h1c000300); regw(0, 5'd2, 32'h7);
      e = ex("idle_wait"); e.pause = 8'h7F; e.state = 2'd2; step(e);
    end
    chk("fc3.idle.state", 64'(b_state), 64'h2);
    nxt(); clr(); raise_int();
    e = ex("wake"); e.pause = 8'h7F; e.state = 2'd2; e.excp_valid = 1'b1; e.excp_pc = 32'h1c000104;
    e.intr = 1'b1; e.redirect = 1'b1; e.new_pc = EENTRY; e.flush = 8'h7F; step(e);
    nxt(); clr();
    step(ex("post_wake"));
    chk("fc3.wake.state", 64'(b_state), 64'h1);
    bubble(1);

    // Asynchronous reset while waiting in idle.
    nxt(); clr();
    slot(0, 32'h1c000400); slot_idle[0] = 1'b1;
    e = ex("idle2"); e.cnt = 2'd1; e.redirect = 1'b1; e.new_pc = 32'h1c000404; e.flush = 8'h7F;
    step(e);
    @(posedge clk); #2;
    chk("idle2.state", 64'(a_state), 64'h2);
    rst = 1'b1; #1;
    chk("midrst.state", 64'(a_state), 64'h0);
    chk("midrst.state3", 64'(b_state), 64'h0);
    chk("midrst.pause", 64'(a_pause), 64'h0);
    chk("midrst.redirect", 64'(a_redirect), 64'h0);
    chk("midrst.retired", a_retired, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; clr(); exp_ret = 0;
    nxt(); clr(); slot(0, 32'h1c000500); regw(0, 5'd1, 32'h1);
    e = ex("after_rst"); e.reg_we = 2'b01; e.cnt = 2'd1; step(e);
    nxt(); clr();
    step(ex("final"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
